spi_burst_sequencer: RTL and testbench

- Upstream/downstream companion to the byte-level SPI master. Queues host bytes in a TX FIFO and feeds them one at a time to the master's byte handshake (tx_byte/TX_DV/tx_ready).
- Collects each received byte (rx_byte/rx_dv) into an RX FIFO.
- Runs multi-byte bursts of programmable length, with underrun fill, overflow drop and a per-byte timeout.

---
 rtl/spi_burst_sequencer.sv | 150 +++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer between a host byte interface and a byte-level SPI master: TX/RX FIFOs plus burst FSM.
// First m_tx_dv two cycles after start; done one cycle after the last m_rx_dv; m_tx_ready low stalls issue; full RX drops bytes.
module spi_burst_sequencer #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         TIMEOUT   = 1023
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          tx_full,
    output logic [AW:0]   tx_level,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rx_empty,
    output logic [AW:0]   rx_level,
    input  logic          start,
    input  logic [7:0]    burst_len,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output logic          overflow,
    output logic          timeout,
    output logic          len_err,
    input  logic          clr_flags,
    output logic [7:0]    m_tx_byte,
    output logic          m_tx_dv,
    input  logic          m_tx_ready,
    input  logic [7:0]    m_rx_byte,
    input  logic          m_rx_dv
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [AW:0]   r_tx_cnt, r_rx_cnt;
    logic [7:0]    r_remaining;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_tx_byte;
    logic          r_tx_dv, r_len_err, r_underrun, r_overflow, r_timeout;

    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_issue, w_tx_pop, w_tx_push, w_rx_pop, w_rx_strobe, w_rx_push, w_rx_drop;
    logic w_tmo, w_start_ok, w_start_zero;

    assign w_tx_empty   = (r_tx_cnt == '0);
    assign w_tx_full    = (r_tx_cnt == (AW+1)'(DEPTH));
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_full    = (r_rx_cnt == (AW+1)'(DEPTH));
    assign w_start_ok   = (r_state == S_IDLE) && start && (burst_len != 8'd0);
    assign w_start_zero = (r_state == S_IDLE) && start && (burst_len == 8'd0);
    assign w_issue      = (r_state == S_ISSUE) && m_tx_ready;
    assign w_tx_pop     = w_issue && !w_tx_empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign w_tx_push    = wr_en && (!w_tx_full || w_tx_pop);
    assign w_rx_pop     = rd_en && !w_rx_empty;
    assign w_rx_strobe  = (r_state == S_WAIT) && m_rx_dv;
    assign w_rx_push    = w_rx_strobe && (!w_rx_full || w_rx_pop);
    assign w_rx_drop    = w_rx_strobe && !w_rx_push;
    // Abort on the edge where the timer would reach TIMEOUT, so done lands TIMEOUT cycles after m_tx_dv.
    assign w_tmo        = (r_state == S_WAIT) && !m_rx_dv && (r_timer >= TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_ISSUE;
            S_ISSUE: if (m_tx_ready) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (m_rx_dv)    w_state_nxt = (r_remaining <= 8'd1) ? S_DONE : S_ISSUE;
                else if (w_tmo) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wr_data;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= m_rx_byte;
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tx_wp     <= '0;
            r_tx_rp     <= '0;
            r_tx_cnt    <= '0;
            r_rx_wp     <= '0;
            r_rx_rp     <= '0;
            r_rx_cnt    <= '0;
            r_remaining <= '0;
            r_timer     <= '0;
            r_tx_byte   <= '0;
            r_tx_dv     <= 1'b0;
            r_len_err   <= 1'b0;
            r_underrun  <= 1'b0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len_err <= w_start_zero;
            r_tx_dv   <= w_issue;

            if (w_issue) begin
                r_tx_byte <= w_tx_empty ? FILL_BYTE : r_tx_mem[r_tx_rp];
                r_timer   <= '0;
            end else if ((r_state == S_WAIT) && (r_timer != TW'(TIMEOUT))) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_start_ok)
                r_remaining <= burst_len;
            else if (w_rx_strobe && (r_remaining != 8'd0))
                r_remaining <= r_remaining - 8'd1;

            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            r_tx_cnt <= r_tx_cnt + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);

            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            r_rx_cnt <= r_rx_cnt + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);

            // Set has priority over clear.
            r_underrun <= (w_issue && w_tx_empty) || (r_underrun && !clr_flags);
            r_overflow <= w_rx_drop || (r_overflow && !clr_flags);
            r_timeout  <= w_tmo || (r_timeout && !clr_flags);
        end
    end

    assign tx_full   = w_tx_full;
    assign tx_level  = r_tx_cnt;
    assign rx_empty  = w_rx_empty;
    assign rx_level  = r_rx_cnt;
    assign rd_data   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign len_err   = r_len_err;
    assign underrun  = r_underrun;
    assign overflow  = r_overflow;
    assign timeout   = r_timeout;
    assign m_tx_byte = r_tx_byte;
    assign m_tx_dv   = r_tx_dv;
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: a loopback SPI master model plus queue-based reference of FIFOs and bursts.
module tb_spi_burst_sequencer;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int TIMEOUT = 1023;
    localparam logic [7:0] FILL = 8'hFF;
    localparam logic [34:0] RST_EXP = {8'h00, 8'b0000_0000, 1'b1, 5'd0, 5'd0, 8'h00};

    logic i_clk = 1'b0;
    logic reset, wr_en, rd_en, start, clr_flags, m_tx_ready, m_rx_dv;
    logic [7:0] wr_data, burst_len, m_rx_byte, rd_data, m_tx_byte;
    logic tx_full, rx_empty, busy, done, underrun, overflow, timeout, len_err, m_tx_dv;
    logic [AW:0] tx_level, rx_level;

    always #5 i_clk = ~i_clk;

    spi_burst_sequencer #(.DEPTH(DEPTH), .AW(AW), .FILL_BYTE(FILL), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
        .tx_level(tx_level), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
        .rx_level(rx_level), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
        .underrun(underrun), .overflow(overflow), .timeout(timeout), .len_err(len_err),
        .clr_flags(clr_flags), .m_tx_byte(m_tx_byte), .m_tx_dv(m_tx_dv),
        .m_tx_ready(m_tx_ready), .m_rx_byte(m_rx_byte), .m_rx_dv(m_rx_dv)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    logic [7:0] sent_q[$];
    int dv_cyc_q[$];
    int done_cnt = 0, done_cyc = 0, len_err_cnt = 0, dv_double = 0;
    bit respond = 1'b1;
    bit stall_en = 1'b0;
    int delay = 20;
    bit pending = 1'b0;
    int pend_cnt = 0;
    logic [7:0] pend_byte = 8'h00;
    logic prev_dv = 1'b0;

    logic [7:0] tx_model[$], rx_model[$], exp_q[$];
    bit exp_unr, exp_ovf;

    // Master model: records every byte pulse and, if enabled, echoes it back after 'delay' cycles.
    initial begin : master
        m_rx_dv = 1'b0;
        m_rx_byte = 8'h00;
        m_tx_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            cyc++;
            m_rx_dv = 1'b0;
            m_tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (reset) pending = 1'b0;
            else if (pending) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    m_rx_dv = 1'b1;
                    m_rx_byte = pend_byte;
                    pending = 1'b0;
                end
            end
            if (m_tx_dv) begin
                sent_q.push_back(m_tx_byte);
                dv_cyc_q.push_back(cyc);
                if (prev_dv) dv_double++;
                if (respond) begin
                    pending = 1'b1;
                    pend_cnt = delay;
                    pend_byte = m_tx_byte;
                end
            end
            prev_dv = m_tx_dv;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (len_err) len_err_cnt++;
        end
    end

    function automatic logic [34:0] rst_vec();
        return {m_tx_byte, m_tx_dv, busy, done, len_err, underrun, overflow, timeout,
                tx_full, rx_empty, tx_level, rx_level, rd_data};
    endfunction

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        if (tx_model.size() < DEPTH) tx_model.push_back(b);
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic read_rx(output logic [7:0] b);
        b = rd_data;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain_rx(output int nbad);
        logic [7:0] b;
        nbad = 0;
        while (rx_model.size() > 0) begin
            read_rx(b);
            if (b !== rx_model.pop_front()) nbad++;
        end
        if (rx_empty !== 1'b1) nbad++;
    endtask

    // Reference: each burst byte comes from the host queue or is FILL, and is looped back into RX if room.
    task automatic model_burst(input int len);
        logic [7:0] b;
        exp_q.delete();
        exp_unr = 1'b0;
        exp_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (tx_model.size() > 0) b = tx_model.pop_front();
            else begin
                b = FILL;
                exp_unr = 1'b1;
            end
            exp_q.push_back(b);
            if (rx_model.size() < DEPTH) rx_model.push_back(b);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic cmp_sent(output int nbad);
        nbad = (sent_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            if (sent_q[i] !== exp_q[i]) nbad++;
    endtask

    task automatic run_burst(input int len, output bit ok, output int start_cyc);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        burst_len = 8'(len);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (rst_vec() !== RST_EXP) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", rst_vec(), RST_EXP);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (rst_vec() !== RST_EXP) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %h expected %h", rst_vec(), RST_EXP);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int sc, nbad, d0;
        delay = 20;
        sent_q.delete();
        dv_cyc_q.delete();
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'h0F);
        d0 = done_cnt;
        model_burst(3);
        run_burst(3, ok, sc);
        tick();
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL basic_done_wait: got no done, expected done"); end
        cmp_sent(nbad);
        n_checks++;
        if (nbad !== 0) begin n_errors++; $display("FAIL basic_sent: %0d bad of %0d sent, expected 0 bad", nbad, sent_q.size()); end
        n_checks++;
        if (dv_cyc_q.size() == 0 || dv_cyc_q[0] - sc != 2) begin
            n_errors++;
            $display("FAIL basic_start_latency: got %0d expected 2", dv_cyc_q.size() ? dv_cyc_q[0] - sc : -1);
        end
        n_checks++;
        if (dv_double !== 0 || done_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL basic_pulses: double_dv=%0d done=%0d expected 0 and 1", dv_double, done_cnt - d0);
        end
        n_checks++;
        if ({underrun, overflow, timeout, busy} !== 4'b0000 || rx_level !== 5'(rx_model.size())) begin
            n_errors++;
            $display("FAIL basic_flags: flags/busy=%b rx_level=%0d expected 0000 and %0d",
                     {underrun, overflow, timeout, busy}, rx_level, rx_model.size());
        end
        drain_rx(nbad);
        n_checks++;
        if (nbad !== 0) begin n_errors++; $display("FAIL basic_rx_data: %0d bad, expected 0", nbad); end
    endtask

    task automatic test_underrun();
        bit ok;
        int sc, nbad;
        sent_q.delete();
        push_byte(8'h55);
        model_burst(3);
        run_burst(3, ok, sc);
        cmp_sent(nbad);
        n_checks++;
        if (!ok || nbad !== 0) begin n_errors++; $display("FAIL underrun_sent: ok=%0d bad=%0d expected 1 and 0", ok, nbad); end
        n_checks++;
        if (underrun !== 1'b1 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_flag: underrun=%b overflow=%b expected 1 0", underrun, overflow);
        end
        clear_flags();
        n_checks++;
        if (underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
        drain_rx(nbad);
        n_checks++;
        if (nbad !== 0) begin n_errors++; $display("FAIL underrun_rx_data: %0d bad, expected 0", nbad); end
    endtask

    task automatic test_overflow();
        bit ok;
        int sc, nbad, d0;
        delay = $urandom_range(2, 30);
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        model_burst(DEPTH);
        run_burst(DEPTH, ok, sc);
        n_checks++;
        if (!ok || rx_level !== 5'(DEPTH) || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_fill: ok=%0d rx_level=%0d overflow=%b expected 1 %0d 0", ok, rx_level, overflow, DEPTH);
        end
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        sent_q.delete();
        d0 = done_cnt;
        model_burst(2);
        run_burst(2, ok, sc);
        cmp_sent(nbad);
        n_checks++;
        if (!ok || nbad !== 0 || done_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL ovf_burst: ok=%0d bad=%0d done=%0d expected 1 0 1", ok, nbad, done_cnt - d0);
        end
        n_checks++;
        if (overflow !== exp_ovf || rx_level !== 5'(DEPTH)) begin
            n_errors++;
            $display("FAIL ovf_flag: overflow=%b rx_level=%0d expected %b %0d", overflow, rx_level, exp_ovf, DEPTH);
        end
        drain_rx(nbad);
        n_checks++;
        if (nbad !== 0) begin n_errors++; $display("FAIL ovf_rx_data: %0d bad, expected 0", nbad); end
        clear_flags();
    endtask

    task automatic test_timeout();
        bit ok;
        int sc;
        // Response on the last allowed cycle is still accepted.
        delay = TIMEOUT - 1;
        push_byte(8'($urandom));
        model_burst(1);
        run_burst(1, ok, sc);
        n_checks++;
        if (!ok || timeout !== 1'b0 || rx_level !== 5'(rx_model.size())) begin
            n_errors++;
            $display("FAIL tmo_edge_accept: ok=%0d timeout=%b rx_level=%0d expected 1 0 %0d", ok, timeout, rx_level, rx_model.size());
        end
        // Master never answers in time: abort after the first byte, leave the rest queued.
        respond = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        dv_cyc_q.delete();
        run_burst(3, ok, sc);
        void'(tx_model.pop_front());
        n_checks++;
        if (!ok || timeout !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_flag: ok=%0d timeout=%b busy=%b expected 1 1 0", ok, timeout, busy);
        end
        n_checks++;
        if (dv_cyc_q.size() !== 1 || done_cyc - dv_cyc_q[0] !== TIMEOUT) begin
            n_errors++;
            $display("FAIL tmo_timing: dv_count=%0d done_delay=%0d expected 1 %0d",
                     dv_cyc_q.size(), dv_cyc_q.size() ? done_cyc - dv_cyc_q[0] : -1, TIMEOUT);
        end
        n_checks++;
        if (tx_level !== 5'(tx_model.size())) begin
            n_errors++;
            $display("FAIL tmo_tx_kept: tx_level=%0d expected %0d", tx_level, tx_model.size());
        end
        respond = 1'b1;
        clear_flags();
        n_checks++;
        if (timeout !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got %b expected 0", timeout); end
    endtask

    task automatic test_len_err_and_busy_start();
        int le0, dvn, d0;
        bit ok;
        le0 = len_err_cnt;
        dvn = dv_cyc_q.size();
        start = 1'b1;
        burst_len = 8'd0;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL lenerr_busy: got %b expected 0", busy); end
        repeat (5) tick();
        n_checks++;
        if (len_err_cnt - le0 !== 1 || dv_cyc_q.size() !== dvn) begin
            n_errors++;
            $display("FAIL lenerr_pulse: len_err=%0d new_dv=%0d expected 1 0", len_err_cnt - le0, dv_cyc_q.size() - dvn);
        end
        delay = 20;
        sent_q.delete();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        model_burst(2);
        d0 = done_cnt;
        start = 1'b1;
        burst_len = 8'd2;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        burst_len = 8'd5;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done_cnt != d0) begin ok = 1'b1; break; end
            tick();
        end
        repeat (40) tick();
        n_checks++;
        if (!ok || sent_q.size() !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_start_ignored: ok=%0d sent=%0d done=%0d busy=%b expected 1 2 1 0",
                     ok, sent_q.size(), done_cnt - d0, busy);
        end
    endtask

    task automatic test_random();
        bit ok;
        int sc, nbad, len, n;
        logic [7:0] b;
        stall_en = 1'b1;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) push_byte(8'($urandom));
            len = $urandom_range(1, 6);
            delay = $urandom_range(1, 30);
            sent_q.delete();
            clear_flags();
            model_burst(len);
            run_burst(len, ok, sc);
            cmp_sent(nbad);
            n_checks++;
            if (!ok || nbad !== 0) begin n_errors++; $display("FAIL rand_sent[%0d]: ok=%0d bad=%0d expected 1 0", it, ok, nbad); end
            n_checks++;
            if (underrun !== exp_unr || overflow !== exp_ovf || tx_level !== 5'(tx_model.size()) ||
                rx_level !== 5'(rx_model.size())) begin
                n_errors++;
                $display("FAIL rand_state[%0d]: unr=%b ovf=%b txl=%0d rxl=%0d expected %b %b %0d %0d", it,
                         underrun, overflow, tx_level, rx_level, exp_unr, exp_ovf, tx_model.size(), rx_model.size());
            end
            n = $urandom_range(0, rx_model.size());
            nbad = 0;
            for (int k = 0; k < n; k++) begin
                read_rx(b);
                if (b !== rx_model.pop_front()) nbad++;
            end
            n_checks++;
            if (nbad !== 0) begin n_errors++; $display("FAIL rand_rx[%0d]: %0d bad, expected 0", it, nbad); end
        end
        stall_en = 1'b0;
        drain_rx(nbad);
        n_checks++;
        if (nbad !== 0) begin n_errors++; $display("FAIL rand_drain: %0d bad, expected 0", nbad); end
    endtask

    task automatic test_reset_midburst();
        int d0, dvn;
        delay = 20;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        dv_cyc_q.delete();
        start = 1'b1;
        burst_len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && dv_cyc_q.size() < 2; i++) tick();
        repeat (3) tick();
        n_checks++;
        if (dv_cyc_q.size() !== 2 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_in_wait: dv=%0d busy=%b expected 2 1", dv_cyc_q.size(), busy);
        end
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rst_vec() !== RST_EXP) begin
            n_errors++;
            $display("FAIL rstmid_async: got %h expected %h", rst_vec(), RST_EXP);
        end
        tick();
        reset = 1'b0;
        tx_model.delete();
        rx_model.delete();
        dvn = dv_cyc_q.size();
        repeat (40) tick();
        n_checks++;
        if (done_cnt !== d0 || dv_cyc_q.size() !== dvn || rst_vec() !== RST_EXP) begin
            n_errors++;
            $display("FAIL rstmid_quiet: done=%0d new_dv=%0d state=%h expected 0 0 %h",
                     done_cnt - d0, dv_cyc_q.size() - dvn, rst_vec(), RST_EXP);
        end
    endtask

    initial begin : main
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        rd_en = 1'b0;
        start = 1'b0;
        burst_len = 8'h00;
        clr_flags = 1'b0;
        test_reset();
        test_basic();
        test_underrun();
        test_overflow();
        test_timeout();
        test_len_err_and_busy_start();
        test_random();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
